keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//  Scans a 4x4 active-low matrix keypad, debounces presses and emits one code per press.
//  Shifts each accepted code into a 4-digit entry buffer.
//  digits[15:0] feeds the 4-digit seven-segment display driver's num_in.
//  Sits between the keypad pins and the lock compare/control logic.
// PARAMETERS
//  SCAN_DIV        default 50000  clk cycles per column dwell (>=4); tick = last cycle of dwell
//  DEBOUNCE_TICKS  default 4      consecutive stable ticks required for press and for release (>=1)
// PORTS
//  clk        in   1   system clock
//  rstn       in   1   asynchronous active-low reset
//  row_in     in   4   keypad rows; async, pulled up, low = key in driven column pressed
//  col_out    out  4   column drive; exactly one bit low (active column), others high
//  clear      in   1   sync clear of entry buffer, 1-cycle pulse or level
//  key_valid  out  1   1-cycle pulse per debounced press
//  key_code   out  4   code of last accepted key = 4*row + col; holds between presses
//  digits     out  16  entry buffer; newest key in [3:0], oldest in [15:12]
//  digit_cnt  out  3   keys in buffer, saturates at 4
// BEHAVIOUR
//  Reset: col_out=4'b1110 (col 0), key_valid=0, key_code=0, digits=0, digit_cnt=0, state=SCAN,
//   prescaler=0, debounce count=0, row synchronizer=4'b1111.
//  row_in passes a 2-flop synchronizer (rows_s); all decisions use rows_s at tick only.
//  Prescaler counts 0..SCAN_DIV-1 continuously in every state; tick when count==SCAN_DIV-1.
//  FSM:
//   SCAN: at tick, any rows_s bit low -> latch col_idx and lowest-index low row,
//    cnt=0, go DEBOUNCE, keep column. Else col_idx=(col_idx+1) mod 4, wraps 3->0.
//   DEBOUNCE: column held. At tick, latched row low -> cnt++.
//    When cnt reaches DEBOUNCE_TICKS, go HELD.
//    Next cycle: key_valid=1, key_code=4*row+col. Latched row high at tick -> SCAN, advance column.
//   HELD: column held. At tick, latched row high -> rel_cnt++; low -> rel_cnt=0.
//    rel_cnt==DEBOUNCE_TICKS -> SCAN, advance column.
//    Further presses (other rows, same column) are ignored until release completes.
//  Detection latency: key_valid asserts DEBOUNCE_TICKS ticks after the detecting tick, +1 clk.
//  Exactly one key_valid per press, however long held. Bounce in DEBOUNCE aborts without a pulse.
//  Entry buffer, on key_valid: digits <= {digits[11:0], key_code}; digit_cnt=min(digit_cnt+1,4).
//   When full, the oldest digit is dropped.
//  clear: digits=0, digit_cnt=0 next cycle.
//   clear with key_valid in the same cycle: clear wins, key not stored, key_valid/key_code still update.
//  clear does not affect scan FSM or key_code.
//  Reset mid-press: all state to reset values. A still-held key is re-detected from SCAN as a new press.
//  Multiple keys in the scanned column at detection: lowest row index wins.
// TESTING (SCAN_DIV=4, DEBOUNCE_TICKS=3 unless noted)
//  1 Reset, no keys -> col_out cycles 1110,1101,1011,0111,1110 every 4 clk; key_valid never 1.
//  2 Hold row1 low while col2 driven, stable 40 clk -> one key_valid, key_code=6;
//    digits=16'h0006, digit_cnt=1; single pulse even if held 200 clk.
//  3 Row0/col3 low for 1 tick then high (bounce) -> no key_valid, scan resumes at col 0.
//  4 Press codes 1,2,3,4,5 in sequence -> digits=16'h2345, digit_cnt=4 (saturated).
//  5 Assert clear on the same cycle as key_valid (code 9) -> digits=0, digit_cnt=0, key_code=9.
//  6 Deassert rstn mid-DEBOUNCE -> outputs at reset values immediately.
//    After release of rstn with key still held -> fresh press detected, key_valid once.

Source files
------------

// File: rtl/keypad_scan.sv
// Scanner, debouncer and 4-digit entry buffer for a 4x4 active-low matrix keypad.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// SCAN     | walking columns, one column per dwell, looking for a low row
// DEBOUNCE | column held, counting stable-low ticks on the latched row
// HELD     | key accepted, counting stable-high ticks until release
module keypad_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    input  logic        clear,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] digits,
    output logic [2:0]  digit_cnt
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    row_meta_q;
    logic [3:0]    rows_s_q;
    logic [PW-1:0] presc_q;
    logic          tick;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          kv_q, kv_d;
    logic [3:0]    kc_q, kc_d;
    logic [15:0]   digits_q, digits_d;
    logic [2:0]    dcnt_q, dcnt_d;
    logic [1:0]    low_row;

    // Two-flop synchronizer on the asynchronous row pins; idle rows read high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_meta_q <= 4'hF;
            rows_s_q   <= 4'hF;
        end else begin
            row_meta_q <= row_in;
            rows_s_q   <= row_meta_q;
        end
    end

    // Free-running dwell prescaler; tick marks the last cycle of each dwell.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    assign tick = (presc_q == PW'(SCAN_DIV - 1));

    // Lowest-index low row wins when several keys share the scanned column.
    always_comb begin
        low_row = 2'd0;
        if (!rows_s_q[0])      low_row = 2'd0;
        else if (!rows_s_q[1]) low_row = 2'd1;
        else if (!rows_s_q[2]) low_row = 2'd2;
        else if (!rows_s_q[3]) low_row = 2'd3;
    end

    // Scan FSM state and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            cnt_q   <= '0;
            kv_q    <= 1'b0;
            kc_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            kv_q    <= kv_d;
            kc_q    <= kc_d;
        end
    end

    // Next-state logic; all decisions are taken only on tick. The same counter
    // serves press debounce and release debounce since the phases never overlap.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        kv_d    = 1'b0;
        kc_d    = kc_q;
        case (state_q)
            SCAN: begin
                if (tick) begin
                    if (rows_s_q != 4'hF) begin
                        row_d   = low_row;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (!rows_s_q[row_q]) begin
                        if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
                            state_d = HELD;
                            cnt_d   = '0;
                            kv_d    = 1'b1;
                            kc_d    = {row_q, col_q};
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_q + 2'd1;
                    end
                end
            end
            HELD: begin
                if (tick) begin
                    if (rows_s_q[row_q]) begin
                        if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
                            state_d = SCAN;
                            cnt_d   = '0;
                            col_d   = col_q + 2'd1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // Entry buffer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            digits_q <= 16'h0000;
            dcnt_q   <= 3'd0;
        end else begin
            digits_q <= digits_d;
            dcnt_q   <= dcnt_d;
        end
    end

    // Shift in each accepted code; clear takes priority over a same-cycle key.
    always_comb begin
        digits_d = digits_q;
        dcnt_d   = dcnt_q;
        if (clear) begin
            digits_d = 16'h0000;
            dcnt_d   = 3'd0;
        end else if (kv_q) begin
            digits_d = {digits_q[11:0], kc_q};
            if (dcnt_q < 3'd4) begin
                dcnt_d = dcnt_q + 3'd1;
            end
        end
    end

    assign col_out   = ~(4'b0001 << col_q);
    assign key_valid = kv_q;
    assign key_code  = kc_q;
    assign digits    = digits_q;
    assign digit_cnt = dcnt_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a small keypad model driving row_in.
module tb_keypad_scan;

    logic        clk;
    logic        rstn;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        clear;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] digits;
    logic [2:0]  digit_cnt;

    logic        kp_on;
    logic [1:0]  kp_r;
    logic [1:0]  kp_c;

    int n_cmp;
    int n_err;
    int vcount;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .row_in   (row_in),
        .col_out  (col_out),
        .clear    (clear),
        .key_valid(key_valid),
        .key_code (key_code),
        .digits   (digits),
        .digit_cnt(digit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_in = 4'hF;
        if (kp_on && !col_out[kp_c]) row_in[kp_r] = 1'b0;
    end

    // Count key_valid pulses.
    always @(negedge clk) begin
        if (key_valid) vcount++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (key_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c, input int hold);
        int  base;
        bit  seen;
        base  = vcount;
        kp_r  = r;
        kp_c  = c;
        kp_on = 1'b1;
        wait_valid(seen);
        chk("valid_seen", 32'(seen), 32'd1);
        chk("key_code", 32'(key_code), 32'({r, c}));
        repeat (hold) @(negedge clk);
        kp_on = 1'b0;
        repeat (40) @(negedge clk);
        chk("pulse_count", 32'(vcount - base), 32'd1);
    endtask

    typedef struct {
        logic [1:0]  r;
        logic [1:0]  c;
        int          hold;
        logic [15:0] exp_digits;
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t vecs[6];
    logic [3:0] col_seq[4];

    initial begin
        bit seen;
        int base;

        n_cmp = 0; n_err = 0; vcount = 0;
        rstn = 1'b0; clear = 1'b0; kp_on = 1'b0; kp_r = 2'd0; kp_c = 2'd0;

        vecs[0] = '{2'd1, 2'd2, 200, 16'h0006, 3'd1};
        vecs[1] = '{2'd0, 2'd1, 5,   16'h0061, 3'd2};
        vecs[2] = '{2'd0, 2'd2, 5,   16'h0612, 3'd3};
        vecs[3] = '{2'd0, 2'd3, 5,   16'h6123, 3'd4};
        vecs[4] = '{2'd1, 2'd0, 5,   16'h1234, 3'd4};
        vecs[5] = '{2'd1, 2'd1, 5,   16'h2345, 3'd4};
        col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        // Reset values and idle column walk.
        repeat (3) @(negedge clk);
        chk("rst_col", 32'(col_out), 32'hE);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_digits", 32'(digits), 32'd0);
        chk("rst_cnt", 32'(digit_cnt), 32'd0);
        rstn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            chk("idle_col", 32'(col_out), 32'(col_seq[(k / 4) % 4]));
            @(negedge clk);
        end
        chk("idle_no_valid", 32'(vcount), 32'd0);

        // Clear coinciding with key_valid: clear wins, key_code still updates.
        kp_r = 2'd2; kp_c = 2'd1; kp_on = 1'b1;
        wait_valid(seen);
        chk("clr_valid_seen", 32'(seen), 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_digits", 32'(digits), 32'd0);
        chk("clr_cnt", 32'(digit_cnt), 32'd0);
        chk("clr_code", 32'(key_code), 32'd9);
        kp_on = 1'b0;
        repeat (40) @(negedge clk);

        // Press sequence from the table.
        for (int i = 0; i < 6; i++) begin
            press(vecs[i].r, vecs[i].c, vecs[i].hold);
            chk("digits", 32'(digits), 32'(vecs[i].exp_digits));
            chk("digit_cnt", 32'(digit_cnt), 32'(vecs[i].exp_cnt));
        end

        // Bounce on row0/col3: one low tick, then high -> abort, resume col 0.
        base = vcount;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (col_out == 4'b0111) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bounce_col3_seen", 32'(seen), 32'd1);
        kp_r = 2'd0; kp_c = 2'd3; kp_on = 1'b1;
        repeat (4) @(negedge clk);
        chk("bounce_col_held", 32'(col_out), 32'h7);
        kp_on = 1'b0;
        repeat (4) @(negedge clk);
        chk("bounce_resume_col0", 32'(col_out), 32'hE);
        repeat (40) @(negedge clk);
        chk("bounce_no_valid", 32'(vcount - base), 32'd0);
        chk("bounce_digits", 32'(digits), 32'h2345);

        // Reset mid-DEBOUNCE with key (row3/col0) still held.
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (col_out == 4'b1101) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst2_sync_seen", 32'(seen), 32'd1);
        repeat (12) @(negedge clk);
        chk("rst2_col0", 32'(col_out), 32'hE);
        kp_r = 2'd3; kp_c = 2'd0; kp_on = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst2_held_col0", 32'(col_out), 32'hE);
        base = vcount;
        rstn = 1'b0;
        #1;
        chk("rst2_col", 32'(col_out), 32'hE);
        chk("rst2_valid", 32'(key_valid), 32'd0);
        chk("rst2_code", 32'(key_code), 32'd0);
        chk("rst2_digits", 32'(digits), 32'd0);
        chk("rst2_cnt", 32'(digit_cnt), 32'd0);
        @(negedge clk);
        chk("rst2_no_early_valid", 32'(vcount - base), 32'd0);
        rstn = 1'b1;
        press(2'd3, 2'd0, 20);
        chk("rst2_digits_after", 32'(digits), 32'h000C);
        chk("rst2_cnt_after", 32'(digit_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
